// File: rtl/riscv32i_pkg.sv
// Shared run-controller types: run state encoding and the riscv-tests tohost encoding rules.
// Combinational helpers only; no state and no flow control.
package riscv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  // A tohost word with LSB set marks "test finished"; the value 1 means pass.
  localparam int TOHOST_PASS = 1;

  function automatic logic tohost_lsb_valid(input logic lsb);
    return lsb == 1'b1;
  endfunction

endpackage

// File: rtl/riscv32i_tohost_mon.sv
// Per-core tohost snooper: latches the first finishing store and whether it reported failure.
// fin/fail/code registered (1 cycle); fin_nxt/fail_nxt give this cycle's view; never stalls the core.
module riscv32i_tohost_mon
  import riscv32i_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] TOHOST_ADDR = 'h1000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              st_valid_i,
  input  logic [DATA_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              fin_o,
  output logic              fail_o,
  output logic [DATA_W-1:0] code_o,
  output logic              fin_nxt_o,
  output logic              fail_nxt_o
);

  logic              fin_q, fin_d;
  logic              fail_q, fail_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              hit, bad;

  always_comb begin
    hit        = en_i & st_valid_i & (st_addr_i == TOHOST_ADDR) & tohost_lsb_valid(st_data_i[0]);
    // Only the first finishing store of a run counts; repeats are ignored.
    bad        = hit & ~fin_q & (st_data_i != DATA_W'(TOHOST_PASS));
    fin_nxt_o  = fin_q | hit;
    fail_nxt_o = fail_q | bad;
    fin_d      = fin_nxt_o;
    fail_d     = fail_nxt_o;
    code_d     = bad ? (st_data_i >> 1) : code_q;
    if (clr_i) begin
      fin_d  = 1'b0;
      fail_d = 1'b0;
      code_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fin_q  <= 1'b0;
      fail_q <= 1'b0;
      code_q <= '0;
    end else begin
      fin_q  <= fin_d;
      fail_q <= fail_d;
      code_q <= code_d;
    end
  end

  assign fin_o  = fin_q;
  assign fail_o = fail_q;
  assign code_o = code_q;

endmodule

// File: rtl/riscv32i_run_ctrl.sv
// Run controller: sequences core resets, bounds the run by a cycle budget, reports tohost verdicts.
// Status updates one edge after the deciding cycle; start/abort are pulses, no backpressure.
module riscv32i_run_ctrl
  import riscv32i_pkg::*;
#(
  parameter int                N_CORES     = 1,
  parameter int                DATA_W      = 32,
  parameter int                RST_CYCLES  = 5,
  parameter int                MAX_CYCLES  = 50,
  parameter int                CNT_W       = 32,
  parameter logic [DATA_W-1:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_CORES-1:0]          st_valid,
  input  logic [N_CORES*DATA_W-1:0]   st_addr,
  input  logic [N_CORES*DATA_W-1:0]   st_data,
  output logic [N_CORES-1:0]          core_rst_o,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        timeout,
  output logic                        aborted,
  output logic [N_CORES-1:0]          fin_mask,
  output logic [DATA_W-1:0]           fail_code,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int                RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]     RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;

  run_state_e         state_q, state_d;
  logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d, pass_q, pass_d;
  logic               timeout_q, timeout_d, aborted_q, aborted_d;

  logic [N_CORES-1:0] mon_fin, mon_fail, mon_fin_nxt, mon_fail_nxt;
  logic [DATA_W-1:0]  mon_code [N_CORES];
  logic               start_acc, run_en, complete, expire;

  assign start_acc = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign run_en    = (state_q == ST_RUN);

  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_mon
    riscv32i_tohost_mon #(
      .DATA_W      (DATA_W),
      .TOHOST_ADDR (TOHOST_ADDR)
    ) u_mon (
      .clk_i      (clk),
      .rst_ni     (reset),
      .clr_i      (start_acc),
      .en_i       (run_en),
      .st_valid_i (st_valid[gi]),
      .st_addr_i  (st_addr[gi*DATA_W +: DATA_W]),
      .st_data_i  (st_data[gi*DATA_W +: DATA_W]),
      .fin_o      (mon_fin[gi]),
      .fail_o     (mon_fail[gi]),
      .code_o     (mon_code[gi]),
      .fin_nxt_o  (mon_fin_nxt[gi]),
      .fail_nxt_o (mon_fail_nxt[gi])
    );
  end

  // Completion counts this cycle's hits, and beats an expiring budget in the same cycle.
  assign complete = run_en & (&mon_fin_nxt);
  assign expire   = run_en & (MAX_CYCLES != 0) & (cnt_q == CNT_LAST) & ~(&mon_fin_nxt);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          cnt_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        if (abort) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (complete) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = ~(|mon_fail_nxt);
        end else if (expire) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      aborted_q <= aborted_d;
    end
  end

  // Lowest-index failing core supplies the reported code.
  always_comb begin
    fail_code = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (mon_fail[i]) fail_code = mon_code[i];
    end
  end

  assign core_rst_o  = {N_CORES{state_q != ST_RUN}};
  assign busy        = (state_q == ST_RESET) | (state_q == ST_RUN);
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign aborted     = aborted_q;
  assign fin_mask    = mon_fin;
  assign fail        = |mon_fail;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_riscv32i_run_ctrl.sv
// Randomized bench for riscv32i_run_ctrl: each run is described by per-core tohost write
// cycles and an optional abort cycle; the expected verdict is derived from those event times.
module tb_riscv32i_run_ctrl;

  localparam int          N      = 2;
  localparam int          DW     = 32;
  localparam int          RSTC   = 5;
  localparam int          MAXC   = 50;
  localparam int          CW     = 32;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int          NEVER  = 1000000;

  logic            clk = 1'b0;
  logic            reset, start, abort;
  logic [N-1:0]    st_valid;
  logic [N*DW-1:0] st_addr, st_data;
  logic [N-1:0]    core_rst_o, fin_mask;
  logic            busy, done, pass, fail, timeout, aborted;
  logic [DW-1:0]   fail_code;
  logic [CW-1:0]   cycle_count;

  riscv32i_run_ctrl #(
    .N_CORES(N), .DATA_W(DW), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CNT_W(CW), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .core_rst_o(core_rst_o), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .aborted(aborted), .fin_mask(fin_mask), .fail_code(fail_code),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Run description in "cycles since the start edge": edges 1..RSTC are RESET, RUN cycle k is edge RSTC+k.
  int          wr_c [N];
  logic [31:0] wr_dat [N];
  int          abort_c;
  int          end_c;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_rst"}, core_rst_o, {N{1'b1}});
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_fin"}, fin_mask, 0);
    check({tag, "_code"}, fail_code, 0);
    check({tag, "_cc"}, cycle_count, 0);
  endtask

  function automatic logic [N-1:0] fin_at(input int lim);
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = (wr_c[i] != 0) && (wr_c[i] <= lim);
    return m;
  endfunction

  function automatic logic [N-1:0] fail_at(input int lim);
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = (wr_c[i] != 0) && (wr_c[i] <= lim) && (wr_dat[i] != 32'd1);
    return m;
  endfunction

  function automatic logic [31:0] code_at(input int lim);
    logic [N-1:0] f = fail_at(lim);
    for (int i = 0; i < N; i++) if (f[i]) return wr_dat[i] >> 1;
    return 32'd0;
  endfunction

  task automatic set_run(input int k0, input logic [31:0] d0, input int k1, input logic [31:0] d1, input int ab);
    wr_c[0]   = (k0 == 0) ? 0 : RSTC + k0;
    wr_c[1]   = (k1 == 0) ? 0 : RSTC + k1;
    wr_dat[0] = d0;
    wr_dat[1] = d1;
    abort_c   = ab;
  endtask

  task automatic clear_inputs();
    start    = 1'b0;
    abort    = 1'b0;
    st_valid = '0;
    st_addr  = '0;
    st_data  = '0;
  endtask

  // Real tohost writes at their scheduled cycle, plus stores that must never register as hits.
  task automatic drive_cycle(input int c);
    clear_inputs();
    for (int i = 0; i < N; i++) begin
      logic        v;
      logic [31:0] a, d;
      v = 1'b0; a = '0; d = '0;
      if (c == wr_c[i]) begin
        v = 1'b1; a = TOHOST; d = wr_dat[i];
      end else if ($urandom_range(0, 2) == 0) begin
        v = 1'b1;
        case ($urandom_range(0, 3))
          0: begin a = TOHOST; d = $urandom & 32'hFFFF_FFFE; end
          1: begin a = TOHOST + 32'd4; d = 32'd1; end
          2: begin a = TOHOST ^ (32'($urandom_range(1, 255)) << 2); d = $urandom; end
          default: begin
            a = TOHOST;
            if (c <= RSTC || (wr_c[i] != 0 && c > wr_c[i]) || c > end_c) d = $urandom | 32'd1;
            else d = 32'd2;
          end
        endcase
      end
      st_valid[i]          = v;
      st_addr[i*DW +: DW]  = a;
      st_data[i*DW +: DW]  = d;
    end
    start = (c <= end_c) && ($urandom_range(0, 15) == 0);
    abort = (c == abort_c) || (c > end_c && $urandom_range(0, 3) == 0);
  endtask

  task automatic do_run(input string tag);
    int          comp_c, to_c, nat_end, cc_e;
    logic        ab_e, to_e, pass_e;
    logic [N-1:0] fin_e, fail_e;
    logic [31:0] code_e;
    comp_c = 0;
    for (int i = 0; i < N; i++) begin
      if (wr_c[i] == 0) comp_c = NEVER;
      else if (comp_c != NEVER && wr_c[i] > comp_c) comp_c = wr_c[i];
    end
    to_c    = RSTC + MAXC;
    nat_end = (comp_c <= to_c) ? comp_c : to_c;
    ab_e    = (abort_c != 0) && (abort_c <= nat_end);
    end_c   = ab_e ? abort_c : nat_end;
    fin_e   = fin_at(end_c);
    fail_e  = fail_at(end_c);
    code_e  = code_at(end_c);
    pass_e  = !ab_e && (comp_c <= to_c) && (fail_e == 0);
    to_e    = !ab_e && (comp_c > to_c);
    cc_e    = (end_c > RSTC) ? end_c - RSTC : 0;

    clear_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_s_done"}, done, 0);
    check({tag, "_s_status"}, {pass, fail, timeout, aborted}, 4'b0000);
    check({tag, "_s_fin"}, fin_mask, 0);
    check({tag, "_s_code"}, fail_code, 0);
    check({tag, "_s_cc"}, cycle_count, 0);
    check({tag, "_s_busy"}, busy, 1);
    check({tag, "_s_core_rst"}, core_rst_o, {N{1'b1}});

    for (int c = 1; c <= end_c + 3; c++) begin
      drive_cycle(c);
      @(posedge clk); #1;
      if (c < end_c) begin
        check({tag, "_m_busy"}, busy, 1);
        check({tag, "_m_done"}, done, 0);
        check({tag, "_m_core_rst"}, core_rst_o, (c < RSTC) ? {N{1'b1}} : {N{1'b0}});
        check({tag, "_m_cc"}, cycle_count, (c < RSTC) ? 0 : c - RSTC);
        check({tag, "_m_fin"}, fin_mask, fin_at(c));
        check({tag, "_m_fail"}, fail, |fail_at(c));
      end else begin
        check({tag, "_e_done"}, done, 1);
        check({tag, "_e_busy"}, busy, 0);
        check({tag, "_e_core_rst"}, core_rst_o, {N{1'b1}});
        check({tag, "_e_pass"}, pass, pass_e);
        check({tag, "_e_fail"}, fail, |fail_e);
        check({tag, "_e_timeout"}, timeout, to_e);
        check({tag, "_e_aborted"}, aborted, ab_e);
        check({tag, "_e_fin"}, fin_mask, fin_e);
        check({tag, "_e_code"}, fail_code, code_e);
        check({tag, "_e_cc"}, cycle_count, cc_e);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    end_c = NEVER;
    set_run(0, 32'd1, 0, 32'd1, 0);
    reset = 1'b0;
    #1;
    check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle");

    set_run(10, 32'd1, 10, 32'd1, 0);              do_run("pass10");
    set_run(20, 32'd1, 3, 32'h15, 0);              do_run("fail_c1");
    set_run(0, 32'd1, 0, 32'd1, 0);                do_run("tmo");
    set_run(50, 32'd1, 50, 32'd1, 0);              do_run("last_cyc");
    set_run(51, 32'd1, 10, 32'd1, 0);              do_run("late");
    set_run(0, 32'd1, 0, 32'd1, RSTC + 30);        do_run("abort_run");
    set_run(7, 32'd1, 7, 32'd1, RSTC + 7);         do_run("abort_tie");
    set_run(0, 32'd1, 0, 32'd1, 3);                do_run("abort_rst");
    set_run(5, 32'd3, 4, 32'd7, 0);                do_run("fail_both");
    set_run(0, 32'd1, 0, 32'd1, RSTC + MAXC);      do_run("abort_tmo");

    for (int r = 0; r < 30; r++) begin
      int          k [N];
      logic [31:0] d [N];
      for (int i = 0; i < N; i++) begin
        k[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 56));
        d[i] = ($urandom_range(0, 2) == 0) ? ($urandom | 32'd1) : 32'd1;
      end
      set_run(k[0], d[0], k[1], d[1], ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 60)) : 0);
      do_run("rnd");
    end

    // Asynchronous reset in the middle of a run.
    set_run(5, 32'd1, 0, 32'd1, 0);
    end_c = NEVER;
    clear_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 15; c++) begin
      drive_cycle(c);
      start = 1'b0;
      abort = 1'b0;
      @(posedge clk); #1;
    end
    clear_inputs();
    check("mr_pre_fin", fin_mask, 2'b01);
    check("mr_pre_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("mr_async");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("mr_idle");

    set_run(12, 32'd1, 8, 32'd1, 0);               do_run("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
